id_scoreboard_ctrl: RTL

- Issue-hazard controller for the decode stage.
- Tracks in-flight register and CSR writes between issue (ID→EX handshake) and retirement (WB).
- Produces the decode stall that replaces per-stage Rd comparison.
- Sequences fence.i by draining the pipeline before the fence may issue.

---
 rtl/id_scoreboard_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/id_scoreboard_ctrl.sv
// ---------------------------------------------------------------------------
// id_scoreboard_ctrl
//
// Issue-hazard controller for the decode stage. Counts in-flight GPR and CSR
// writes from issue (ID->EX handshake) to retirement (WB) and produces the
// decode stall. It also drains the pipeline before a fence.i may issue.
//
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   id_*                     : instruction currently held in ID
//   id_fire                  : ID->EX transfer this cycle
//   flush                    : mispredict, instruction in ID is squashed
//   wb_fire, wb_rd, wb_rd_we,
//   wb_csr_we                : retirement in WB
//   stall                    : ID must not issue (OR of the three hazards)
//   raw_stall                : a source operand or CSR is still pending
//   struct_stall             : per-register counter full or in-flight limit
//   fence_stall              : fence.i waiting for the pipeline to drain
//   busy_mask                : bit r set while register r has pending writes
//   inflight                 : number of issued, not yet retired instructions
//   sb_err                   : sticky, a retirement underflowed a counter
// ---------------------------------------------------------------------------
module id_scoreboard_ctrl #(
  parameter int NREG    = 16,
  parameter int CNT_W   = 2,
  parameter int INF_W   = 3,
  parameter int INF_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic             id_rs1_used,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_we,
  input  logic             id_csr_re,
  input  logic             id_csr_we,
  input  logic             id_fence,
  input  logic             id_fire,
  input  logic             flush,
  input  logic             wb_fire,
  input  logic [4:0]       wb_rd,
  input  logic             wb_rd_we,
  input  logic             wb_csr_we,
  output logic             stall,
  output logic             raw_stall,
  output logic             struct_stall,
  output logic             fence_stall,
  output logic [NREG-1:0]  busy_mask,
  output logic [INF_W-1:0] inflight,
  output logic             sb_err
);

  localparam int IW = $clog2(NREG);
  localparam logic [CNT_W-1:0] CNT_FULL  = '1;
  localparam logic [INF_W-1:0] INF_LIMIT = INF_W'(INF_MAX);

  typedef enum logic {IDLE, DRAIN} fence_state_t;

  fence_state_t     state, state_next;
  logic [CNT_W-1:0] pending [NREG];
  logic [CNT_W-1:0] csr_pend;

  logic             issue, retire;
  logic [IW-1:0]    rs1_idx, rs2_idx, rd_idx, wb_idx;
  logic [NREG-1:0]  pend_inc, pend_dec;
  logic             csr_inc, csr_dec;
  logic             underflow;

  assign issue   = id_fire & ~flush;
  assign retire  = wb_fire;
  assign rs1_idx = id_rs1[IW-1:0];
  assign rs2_idx = id_rs2[IW-1:0];
  assign rd_idx  = id_rd[IW-1:0];
  assign wb_idx  = wb_rd[IW-1:0];
  assign csr_inc = issue & id_csr_we;
  assign csr_dec = retire & wb_csr_we;

  // Per-register increment/decrement strobes. Index 0 (x0) is never
  // tracked, so its strobes stay low and its counter stays at zero.
  always_comb begin
    pend_inc = '0;
    pend_dec = '0;
    for (int r = 1; r < NREG; r++) begin
      pend_inc[r] = issue & id_rd_we & (id_rd != 5'd0) & (rd_idx == IW'(r));
      pend_dec[r] = retire & wb_rd_we & (wb_rd != 5'd0) & (wb_idx == IW'(r));
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_mask[r] = (pending[r] != '0);
    end
  end

  // A decrement of an empty counter that is not cancelled by a same-cycle
  // increment is an underflow; the counter holds and the error latches.
  assign underflow = (|(pend_dec & ~pend_inc & ~busy_mask))
                   | (csr_dec & ~csr_inc & (csr_pend == '0))
                   | (retire & ~issue & (inflight == '0));

  // Counters: issue and retire on the same counter cancel each other.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        pending[r] <= '0;
      end
      csr_pend <= '0;
      inflight <= '0;
      sb_err   <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (pend_inc[r] & ~pend_dec[r]) begin
          pending[r] <= pending[r] + 1'b1;
        end else if (pend_dec[r] & ~pend_inc[r] & busy_mask[r]) begin
          pending[r] <= pending[r] - 1'b1;
        end
      end
      if (csr_inc & ~csr_dec) begin
        csr_pend <= csr_pend + 1'b1;
      end else if (csr_dec & ~csr_inc & (csr_pend != '0)) begin
        csr_pend <= csr_pend - 1'b1;
      end
      if (issue & ~retire) begin
        inflight <= inflight + 1'b1;
      end else if (retire & ~issue & (inflight != '0)) begin
        inflight <= inflight - 1'b1;
      end
      sb_err <= sb_err | underflow;
    end
  end

  // Hazards come straight from the registered counters; there is no WB
  // bypass, so a dependent instruction waits until the cycle after wb_fire.
  assign raw_stall = id_valid & (
                       (id_rs1_used & (id_rs1 != 5'd0) & (pending[rs1_idx] != '0))
                     | (id_rs2_used & (id_rs2 != 5'd0) & (pending[rs2_idx] != '0))
                     | (id_csr_re & (csr_pend != '0)));

  assign struct_stall = id_valid & (
                          (id_rd_we & (id_rd != 5'd0) & (pending[rd_idx] == CNT_FULL))
                        | (inflight == INF_LIMIT));

  // Fence state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fence next-state: the stall is raised combinationally in the cycle the
  // fence is first seen, and held in DRAIN regardless of id_valid.
  always_comb begin
    state_next  = state;
    fence_stall = 1'b0;
    case (state)
      IDLE: begin
        if (id_valid & id_fence & (inflight != '0)) begin
          state_next  = DRAIN;
          fence_stall = 1'b1;
        end
      end
      DRAIN: begin
        fence_stall = 1'b1;
        if ((inflight == '0) | flush) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall = raw_stall | struct_stall | fence_stall;

endmodule
